// File: rtl/mat_mult_arbiter.sv
// Round-robin arbiter that hands a single shared mat_mult engine to one of NREQ requesters.
// Each operation runs LOAD (one mat_mult reset cycle), RUN (a mode-dependent cycle count)
// and DONE (a one-cycle result-valid pulse). Operands and mode go to the engine from
// registers and are zero/serial whenever nobody owns it, so they can be OR-combined safely.
module mat_mult_arbiter #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned SER_CYCLES = 7,
  parameter int unsigned PAR_CYCLES = 8,
  localparam int unsigned MatW      = 6 * 6 * 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            mode_req,
  input  logic [NREQ-1:0][MatW-1:0]  dataa_in,
  input  logic [NREQ-1:0][MatW-1:0]  datab_in,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic                       abort,
  output logic                       busy,
  output logic                       mm_rst,
  output logic                       mm_mat_mode,
  output logic [MatW-1:0]            mm_dataa,
  output logic [MatW-1:0]            mm_datab
);

  localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MaxCyc = (SER_CYCLES > PAR_CYCLES) ? SER_CYCLES : PAR_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   owner_q;
  logic [CntW-1:0]   cnt_q;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [NREQ-1:0]   win_onehot;
  logic [IdxW-1:0]   ptr_next;
  int unsigned       rr_idx;

  // Round-robin search: first asserted request at or after ptr, wrapping around.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    rr_idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = 32'(ptr_q) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!win_found && req[rr_idx[IdxW-1:0]]) begin
        win_found                      = 1'b1;
        win_idx                        = rr_idx[IdxW-1:0];
        win_onehot[rr_idx[IdxW-1:0]]   = 1'b1;
      end
    end
  end

  // Pointer moves just past the owner of a completed operation.
  always_comb begin
    ptr_next = owner_q + 1'b1;
    if (32'(owner_q) == NREQ - 1) ptr_next = '0;
  end

  // Main FSM; every output except the state decodes below is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      grant       <= '0;
      done        <= '0;
      abort       <= 1'b0;
      mm_mat_mode <= 1'b1;
      mm_dataa    <= '0;
      mm_datab    <= '0;
    end else if (en) begin
      // Pulses last exactly one enabled cycle.
      done  <= '0;
      abort <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            owner_q     <= win_idx;
            grant       <= win_onehot;
            mm_mat_mode <= mode_req[win_idx];
            mm_dataa    <= dataa_in[win_idx];
            mm_datab    <= datab_in[win_idx];
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          if (!req[owner_q]) begin
            // Owner withdrew: release the engine without moving the pointer.
            abort       <= 1'b1;
            grant       <= '0;
            mm_mat_mode <= 1'b1;
            mm_dataa    <= '0;
            mm_datab    <= '0;
            state_q     <= StIdle;
          end else begin
            cnt_q   <= mm_mat_mode ? CntW'(SER_CYCLES - 1) : CntW'(PAR_CYCLES - 1);
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!req[owner_q]) begin
            abort       <= 1'b1;
            grant       <= '0;
            mm_mat_mode <= 1'b1;
            mm_dataa    <= '0;
            mm_datab    <= '0;
            state_q     <= StIdle;
          end else if (cnt_q == '0) begin
            done    <= grant;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          grant       <= '0;
          mm_mat_mode <= 1'b1;
          mm_dataa    <= '0;
          mm_datab    <= '0;
          ptr_q       <= ptr_next;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign mm_rst = (state_q == StLoad);

endmodule

// File: tb/tb_mat_mult_arbiter.sv
// Self-checking bench for mat_mult_arbiter: directed scenarios with randomized operands,
// modes and request masks, checked against a transaction-level timeline model.
module tb_mat_mult_arbiter;

  localparam int NREQ = 3;
  localparam int SER  = 7;
  localparam int PAR  = 8;
  localparam int MatW = 6 * 6 * 36;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           mode_req;
  logic [NREQ-1:0][MatW-1:0] dataa_in;
  logic [NREQ-1:0][MatW-1:0] datab_in;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           done;
  logic                      abort;
  logic                      busy;
  logic                      mm_rst;
  logic                      mm_mat_mode;
  logic [MatW-1:0]           mm_dataa;
  logic [MatW-1:0]           mm_datab;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  mat_mult_arbiter #(
    .NREQ       (NREQ),
    .SER_CYCLES (SER),
    .PAR_CYCLES (PAR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .mode_req    (mode_req),
    .dataa_in    (dataa_in),
    .datab_in    (datab_in),
    .grant       (grant),
    .done        (done),
    .abort       (abort),
    .busy        (busy),
    .mm_rst      (mm_rst),
    .mm_mat_mode (mm_mat_mode),
    .mm_dataa    (mm_dataa),
    .mm_datab    (mm_datab)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input logic [MatW-1:0] obs,
                         input logic [MatW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed(lo64)=%0h expected(lo64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [MatW-1:0] rand_mat();
    logic [MatW-1:0] m;
    logic [63:0]     t;
    m = '0;
    for (int k = 0; k < 36; k++) begin
      t = {$urandom(), $urandom()};
      m[k*36 +: 36] = t[35:0];
    end
    return m;
  endfunction

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < NREQ; i++) begin
      dataa_in[i] = rand_mat();
      datab_in[i] = rand_mat();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_abort"}, 64'(abort), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mmrst"}, 64'(mm_rst), 64'd0);
    chk({tag, "_mode"}, 64'(mm_mat_mode), 64'd1);
    chk_mat({tag, "_dataa"}, mm_dataa, '0);
    chk_mat({tag, "_datab"}, mm_datab, '0);
  endtask

  // Expected outputs at cycle 'off' after the arbitration edge: LOAD at 1, RUN 2..n+1,
  // DONE at n+2, IDLE at n+3.
  task automatic check_op(input int off, input int n, input logic [NREQ-1:0] oh,
                          input logic mode, input logic [MatW-1:0] ea,
                          input logic [MatW-1:0] eb);
    bit act;
    act = (off <= n + 2);
    chk($sformatf("grant@%0d", off), 64'(grant), act ? 64'(oh) : 64'd0);
    chk($sformatf("busy@%0d", off), 64'(busy), act ? 64'd1 : 64'd0);
    chk($sformatf("mmrst@%0d", off), 64'(mm_rst), (off == 1) ? 64'd1 : 64'd0);
    chk($sformatf("done@%0d", off), 64'(done), (off == n + 2) ? 64'(oh) : 64'd0);
    chk($sformatf("abort@%0d", off), 64'(abort), 64'd0);
    chk($sformatf("mode@%0d", off), 64'(mm_mat_mode), act ? 64'(mode) : 64'd1);
    chk_mat($sformatf("dataa@%0d", off), mm_dataa, act ? ea : '0);
    chk_mat($sformatf("datab@%0d", off), mm_datab, act ? eb : '0);
  endtask

  // Runs one operation from the IDLE cycle in which the winner's request is presented.
  // Returns in the IDLE cycle after DONE (or in the abort cycle when drop_off is hit).
  task automatic do_op(input int w, input logic mode, input int stall_off,
                       input int stall_len, input int drop_off, input bit toggle);
    int              n;
    logic [NREQ-1:0] oh;
    logic [MatW-1:0] ea;
    logic [MatW-1:0] eb;
    n  = mode ? SER : PAR;
    oh = NREQ'(1) << w;
    ea = dataa_in[w];
    eb = datab_in[w];
    for (int off = 1; off <= n + 3; off++) begin
      tick();
      check_op(off, n, oh, mode, ea, eb);
      if (off == stall_off) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check_op(off, n, oh, mode, ea, eb);
        end
        en = 1'b1;
      end
      if (toggle && off <= n + 1) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i != w) begin
            req[i]      = 1'($urandom_range(0, 1));
            mode_req[i] = 1'($urandom_range(0, 1));
            dataa_in[i] = rand_mat();
            datab_in[i] = rand_mat();
          end
        end
      end
      if (off == drop_off) begin
        req[w] = 1'b0;
        tick();
        chk("abort_pulse", 64'(abort), 64'd1);
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_mode", 64'(mm_mat_mode), 64'd1);
        chk_mat("abort_dataa", mm_dataa, '0);
        break;
      end
    end
  endtask

  initial begin
    int   w;
    logic md;
    rst      = 1'b1;
    en       = 1'b0;
    req      = '0;
    mode_req = '0;
    randomize_data();

    // Reset wins over en=0.
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    en  = 1'b1;

    // Idle isolation with random operands on the inputs.
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      tick();
      check_idle("idle_iso");
    end

    // Single serial op on requester 0.
    req      = 3'b001;
    mode_req = 3'b111;
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 0, 0, 0, 1'b0);
    m_ptr = (w + 1) % NREQ;
    req   = '0;
    tick();
    check_idle("after_ser");

    // Parallel op on requester 1.
    randomize_data();
    req      = 3'b010;
    mode_req = 3'b000;
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 0, 0, 0, 1'b0);
    m_ptr = (w + 1) % NREQ;
    req   = '0;
    tick();
    check_idle("after_par");

    // Contention straight after reset: all requests held, round-robin order.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_ptr = 0;
    check_idle("rst2");
    randomize_data();
    req      = 3'b111;
    mode_req = 3'($urandom_range(0, 7));
    for (int i = 0; i < 4; i++) begin
      w = rr_pick(req, m_ptr);
      do_op(w, mode_req[w], 0, 0, 0, 1'b0);
      m_ptr = (w + 1) % NREQ;
    end
    req = '0;
    tick();
    check_idle("after_cont");

    // Random masks, modes, stalls and non-owner input churn.
    for (int r = 0; r < 6; r++) begin
      randomize_data();
      req      = 3'($urandom_range(1, 7));
      mode_req = 3'($urandom_range(0, 7));
      w  = rr_pick(req, m_ptr);
      md = mode_req[w];
      if ($urandom_range(0, 1) == 1)
        do_op(w, md, $urandom_range(1, (md ? SER : PAR) + 2), $urandom_range(1, 3), 0, 1'b1);
      else
        do_op(w, md, 0, 0, 0, 1'b1);
      m_ptr = (w + 1) % NREQ;
    end
    req = '0;
    tick();
    check_idle("after_rand");

    // Abort: give the pointer to requester 2, then withdraw it in RUN cycle 3.
    randomize_data();
    req = 3'b010;
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 0, 0, 0, 1'b0);
    m_ptr = (w + 1) % NREQ;
    req      = 3'b101;
    mode_req = 3'($urandom_range(0, 7));
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 0, 0, 4, 1'b0);
    req[2] = 1'b1;
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 0, 0, 0, 1'b0);
    m_ptr = (w + 1) % NREQ;
    req = '0;
    tick();
    check_idle("after_abort");

    // en low for 5 cycles mid-RUN.
    randomize_data();
    req      = 3'b001;
    mode_req = 3'b001;
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 4, 5, 0, 1'b0);
    m_ptr = (w + 1) % NREQ;
    req = '0;
    tick();
    check_idle("after_stall");

    // Reset during RUN abandons the op; first arbitration afterwards favours requester 0.
    req      = 3'b010;
    mode_req = 3'b111;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check_idle("rst_run");
    rst   = 1'b0;
    req   = '0;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post_rst");
    end
    randomize_data();
    req = 3'b111;
    w = rr_pick(req, m_ptr);
    do_op(w, mode_req[w], 0, 0, 0, 1'b0);
    req = '0;
    tick();
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
